seq_mul: RTL and testbench

- Bit-serial shift-add unsigned multiplier.
- Multiplicand is presented in parallel on `mul`. Multiplier bits arrive serially on `test`, LSB first, one bit per clock.
- Product accumulates in a registered output `prod`. Used as a compact, low-area multiply block where latency of WIDTH cycles is acceptable.

---
 rtl/seq_mul.sv | 75 +++++++
 tb/tb_seq_mul.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/seq_mul.sv
// Bit-serial shift-add unsigned multiplier: multiplier bits arrive LSB first on test.
// Optional completion flag output `done` is enabled with `define SEQ_MUL_DONE_EN.
module seq_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               test,
  input  logic [WIDTH-1:0]   mul,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] prod
`ifdef SEQ_MUL_DONE_EN
  ,
  output logic               done
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(WIDTH);

  logic [CW-1:0]        cnt;
  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     operand;
  logic [2*WIDTH-1:0]   addend;
  logic                 active;

  // b is a parallel copy of the multiplier kept only for interface compatibility.
  logic unused_b;
  assign unused_b = ^b;

  function automatic logic [2*WIDTH-1:0] weighted_addend(
    input logic [WIDTH-1:0] op,
    input logic [CW-1:0]    sh
  );
    return {{WIDTH{1'b0}}, op} << sh;
  endfunction

  always_comb begin
    active  = (cnt < CNT_DONE);
    operand = (cnt == '0) ? mul : mcand;
    addend  = weighted_addend(operand, cnt);
  end

  // Accumulate stage: state only moves while bits remain, so X on test is harmless afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      prod  <= '0;
      cnt   <= '0;
      mcand <= '0;
    end else if (active) begin
      if (cnt == '0) begin
        mcand <= mul;
      end
      if (test) begin
        prod <= prod + addend;
      end
      cnt <= cnt + CW'(1);
    end
  end

`ifdef SEQ_MUL_DONE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      done <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      done <= 1'b1;
    end
  end
`else
  logic unused_last;
  assign unused_last = ^CNT_LAST;
`endif

endmodule

// File: tb/tb_seq_mul.sv
// Self-checking bench for seq_mul: directed and randomized multiplications
// compared against an arithmetic reference (mcand * multiplier bits seen so far).
module tb_seq_mul;

  localparam int W = 8;

  logic             clk;
  logic             reset;
  logic             test;
  logic [W-1:0]     mul;
  logic [W-1:0]     b;
  logic [2*W-1:0]   prod;
`ifdef SEQ_MUL_DONE_EN
  logic             done;
`endif

  int vectors;
  int errors;

  seq_mul #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .test  (test),
    .mul   (mul),
    .b     (b),
    .prod  (prod)
`ifdef SEQ_MUL_DONE_EN
    ,
    .done  (done)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    reset = 1'b1;
    test  = 1'bx;
    mul   = W'($urandom);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Feed one multiplication and check prod after every edge, then check it holds.
  task automatic run_mult(input int mv, input int m, input bit chg_mul, input string name);
    int exp_v;
    for (int k = 0; k < W; k++) begin
      test = m[k];
      b    = W'(m);
      mul  = (k == 0 || !chg_mul) ? W'(mv) : W'($urandom);
      @(posedge clk); #1;
      exp_v = mv * (m % (1 << (k + 1)));
      vectors++;
      if (prod !== (2*W)'(exp_v)) begin
        errors++;
        $display("FAIL %s edge%0d: prod=%0d expected %0d", name, k + 1, prod, exp_v);
      end
`ifdef SEQ_MUL_DONE_EN
      vectors++;
      if (done !== (k == W - 1)) begin
        errors++;
        $display("FAIL %s done edge%0d: done=%b expected %b", name, k + 1, done, (k == W - 1));
      end
`endif
    end
    for (int h = 0; h < 3; h++) begin
      test = (h == 1) ? 1'bx : 1'($urandom);
      mul  = W'($urandom);
      @(posedge clk); #1;
      vectors++;
      if (prod !== (2*W)'(mv * m)) begin
        errors++;
        $display("FAIL %s hold%0d: prod=%0d expected %0d", name, h, prod, mv * m);
      end
    end
  endtask

  task automatic test_reset();
    test = 1'b1;
    mul  = 8'hff;
    b    = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (prod !== '0) begin
      errors++;
      $display("FAIL reset: prod=%0d expected 0", prod);
    end
`ifdef SEQ_MUL_DONE_EN
    vectors++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL reset done: done=%b expected 0", done);
    end
`endif
    reset = 1'b0;
  endtask

  task automatic test_directed();
    run_mult(37, 16, 1'b0, "m37x16");
    do_reset();
    run_mult(255, 255, 1'b0, "m255x255");
    do_reset();
    run_mult(0, int'($urandom_range(0, 255)), 1'b0, "m0");
    do_reset();
    run_mult(200, 0, 1'b0, "m200x0");
    do_reset();
  endtask

  task automatic test_mul_change();
    run_mult(13, 5, 1'b1, "mulchange");
    do_reset();
  endtask

  task automatic test_reset_mid();
    mul = 8'd10;
    for (int k = 0; k < 3; k++) begin
      test = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if (prod !== (2*W)'(10 * ((1 << (k + 1)) - 1))) begin
        errors++;
        $display("FAIL midreset partial%0d: prod=%0d expected %0d", k, prod, 10 * ((1 << (k + 1)) - 1));
      end
    end
    do_reset();
    vectors++;
    if (prod !== '0) begin
      errors++;
      $display("FAIL midreset clear: prod=%0d expected 0", prod);
    end
    run_mult(10, 3, 1'b0, "after_midreset");
    do_reset();
  endtask

  task automatic test_random();
    for (int r = 0; r < 20; r++) begin
      run_mult(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), r[0], "random");
      do_reset();
    end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    reset   = 1'b1;
    test    = 1'b0;
    mul     = '0;
    b       = '0;
    test_reset();
    test_directed();
    test_mul_change();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
